// File: rtl/immediate_encoder.sv
// immediate_encoder: packs RV64 instruction fields and an immediate into a 32-bit instruction word.
// Behind it is a 2-entry output FIFO and a saturating counter of error entries.
// Optional feature macro: IMMEDIATE_RANGE_CHECK_EN. When it is defined, an entry is also
// flagged if the immediate is not representable in the selected format.
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_valid / o_ready                   request handshake
//   i_type [r,i,s,b,u,j], i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm
//                                       decoded fields
//   o_valid / i_ready                   FIFO head handshake
//   o_inst, o_err                       head instruction word and its error flag
//   o_err_count                         saturating count of flagged entries pushed
module immediate_encoder (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_type,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic        o_err,
  output logic [7:0]  o_err_count
);
  logic [32:0] mem_q [2];
  logic [1:0]  count_q, count_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [31:0] inst_d;
  logic        err_d, onehot, range_err, push, pop;
  assign onehot = (i_type != 6'd0) && ((i_type & (i_type - 6'd1)) == 6'd0);
`ifdef IMMEDIATE_RANGE_CHECK_EN
  logic sx11, sx12, sx20;
  assign sx11 = &i_imm[31:11] | ~|i_imm[31:11];
  assign sx12 = &i_imm[31:12] | ~|i_imm[31:12];
  assign sx20 = &i_imm[31:20] | ~|i_imm[31:20];
  assign range_err = ((i_type[4] | i_type[3]) & ~sx11)
                   | (i_type[2] & (i_imm[0] | ~sx12))
                   | (i_type[1] & |i_imm[11:0])
                   | (i_type[0] & (i_imm[0] | ~sx20));
`else
  assign range_err = 1'b0;
`endif
  always_comb begin
    inst_d = !onehot   ? 32'd0 :
             i_type[5] ? {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode} :
             i_type[4] ? {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode} :
             i_type[3] ? {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode} :
             i_type[2] ? {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode} :
             i_type[1] ? {i_imm[31:12], i_rd, i_opcode} :
                         {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
    err_d = !onehot | range_err;
  end
  assign o_ready = count_q != 2'd2;
  assign o_valid = count_q != 2'd0;
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;
  assign o_inst  = mem_q[rd_q][32:1];
  assign o_err   = mem_q[rd_q][0];
  always_comb begin
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    wr_d      = push ? ~wr_q : wr_q;
    rd_d      = pop ? ~rd_q : rd_q;
    err_cnt_d = (push && err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q   <= 2'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_cnt_q <= 8'd0;
      mem_q[0]  <= 33'd0;
      mem_q[1]  <= 33'd0;
    end else begin
      count_q   <= count_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      err_cnt_q <= err_cnt_d;
      if (push) mem_q[wr_q] <= {inst_d, err_d};
    end
  end
  assign o_err_count = err_cnt_q;
endmodule

// File: tb/tb_immediate_encoder.sv
// tb_immediate_encoder: directed self-checking bench for immediate_encoder.
module tb_immediate_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready_o;
  logic [5:0]  typ = 6'd0;
  logic [6:0]  opc = 7'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]  f3 = 3'd0;
  logic [6:0]  f7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic        valid_o;
  logic        ready = 1'b0;
  logic [31:0] inst;
  logic        err;
  logic [7:0]  err_count;
  int n_cmp = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  localparam logic [5:0] T_R = 6'b100000, T_I = 6'b010000, T_S = 6'b001000,
                         T_B = 6'b000100, T_U = 6'b000010, T_J = 6'b000001;
  immediate_encoder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_o),
    .i_type(typ), .i_opcode(opc), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_funct3(f3), .i_funct7(f7), .i_imm(imm), .o_valid(valid_o), .i_ready(ready),
    .o_inst(inst), .o_err(err), .o_err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic set_req(input logic [5:0] t, input logic [6:0] o, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                         input logic [31:0] im);
    typ = t; opc = o; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; imm = im; valid = 1'b1;
  endtask
  task automatic test_reset;
    #2;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    n_cmp++; if (inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_itype;
    @(negedge clk);
    ready = 1'b1;
    set_req(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF);
    @(posedge clk); #1 valid = 1'b0;
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL itype_valid got %b want 1", valid_o); end
    n_cmp++; if (inst !== 32'hFFF00093) begin n_fail++; $display("FAIL itype_inst got %h want fff00093", inst); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL itype_err got %b want 0", err); end
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL itype_drained got %b want 0", valid_o); end
  endtask
  task automatic test_back_to_back;
    logic [5:0]  t [4] = '{T_S, T_B, T_U, T_J};
    logic [6:0]  o [4] = '{7'h23, 7'h63, 7'h37, 7'h6F};
    logic [4:0]  d [4] = '{5'd0, 5'd0, 5'd5, 5'd1};
    logic [4:0]  a [4] = '{5'd3, 5'd0, 5'd0, 5'd0};
    logic [4:0]  b [4] = '{5'd2, 5'd0, 5'd0, 5'd0};
    logic [2:0]  f [4] = '{3'd2, 3'd0, 3'd0, 3'd0};
    logic [31:0] m [4] = '{32'hFFFFFFFC, 32'd8, 32'h12345000, 32'h800};
    logic [31:0] e [4] = '{32'hFE21AE23, 32'h00000463, 32'h123452B7, 32'h001000EF};
    @(negedge clk);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(t[i], o[i], d[i], a[i], b[i], f[i], m[i]);
      @(posedge clk); #1;
      n_cmp++; if (valid_o !== 1'b1 || inst !== e[i]) begin n_fail++; $display("FAIL b2b_%0d got v=%b %h want v=1 %h", i, valid_o, inst, e[i]); end
    end
    valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %b want 0", valid_o); end
  endtask
  task automatic test_backpressure;
    @(negedge clk);
    ready = 1'b0;
    set_req(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    @(posedge clk); #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b want 1", ready_o); end
    set_req(T_I, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
    @(posedge clk); #1;
    n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready2 got %b want 0", ready_o); end
    n_cmp++; if (inst !== 32'h00100093) begin n_fail++; $display("FAIL bp_head0 got %h want 00100093", inst); end
    set_req(T_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3);
    @(posedge clk); #1;
    n_cmp++; if (ready_o !== 1'b0 || valid_o !== 1'b1 || inst !== 32'h00100093) begin n_fail++; $display("FAIL bp_held got r=%b v=%b %h want r=0 v=1 00100093", ready_o, valid_o, inst); end
    ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ready_o !== 1'b1 || inst !== 32'h00200113) begin n_fail++; $display("FAIL bp_drain1 got r=%b %h want r=1 00200113", ready_o, inst); end
    @(posedge clk); #1 valid = 1'b0;
    n_cmp++; if (valid_o !== 1'b1 || inst !== 32'h00300193) begin n_fail++; $display("FAIL bp_drain2 got v=%b %h want v=1 00300193", valid_o, inst); end
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", valid_o); end
  endtask
  task automatic test_errors;
    logic exp_rng;
`ifdef IMMEDIATE_RANGE_CHECK_EN
    exp_rng = 1'b1;
`else
    exp_rng = 1'b0;
`endif
    @(negedge clk);
    ready = 1'b1;
    set_req(6'b000000, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 32'h123);
    @(posedge clk); #1;
    exp_cnt++;
    n_cmp++; if (inst !== 32'd0 || err !== 1'b1) begin n_fail++; $display("FAIL err_zero got %h e=%b want 0 e=1", inst, err); end
    n_cmp++; if (err_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL err_cnt1 got %0d want %0d", err_count, exp_cnt); end
    set_req(T_R | T_I, 7'h33, 5'd1, 5'd1, 5'd1, 3'd1, 32'h1);
    @(posedge clk); #1;
    exp_cnt++;
    n_cmp++; if (inst !== 32'd0 || err !== 1'b1) begin n_fail++; $display("FAIL err_multi got %h e=%b want 0 e=1", inst, err); end
    set_req(T_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h800);
    @(posedge clk); #1 valid = 1'b0;
    if (exp_rng) exp_cnt++;
    n_cmp++; if (inst !== 32'h80000013 || err !== exp_rng) begin n_fail++; $display("FAIL err_range got %h e=%b want 80000013 e=%b", inst, err, exp_rng); end
    n_cmp++; if (err_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL err_cnt2 got %0d want %0d", err_count, exp_cnt); end
    set_req(T_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFF);
    f7 = 7'h20;
    @(posedge clk); #1 valid = 1'b0;
    n_cmp++; if (inst !== 32'h402081B3 || err !== 1'b0) begin n_fail++; $display("FAIL rtype got %h e=%b want 402081b3 e=0", inst, err); end
    @(posedge clk); #1;
  endtask
  task automatic test_saturation;
    @(negedge clk);
    ready = 1'b1;
    set_req(6'b000000, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    repeat (300) @(posedge clk);
    #1 valid = 1'b0;
    exp_cnt = (exp_cnt + 300 > 255) ? 255 : exp_cnt + 300;
    n_cmp++; if (err_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL sat got %0d want %0d", err_count, exp_cnt); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    ready = 1'b0;
    set_req(T_I, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
    repeat (2) @(posedge clk);
    #1 valid = 1'b0;
    n_cmp++; if (valid_o !== 1'b1 || ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_full got v=%b r=%b want v=1 r=0", valid_o, ready_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0 || err_count !== 8'd0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset got v=%b cnt=%0d r=%b want v=0 cnt=0 r=1", valid_o, err_count, ready_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    ready = 1'b1;
    set_req(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    @(posedge clk); #1 valid = 1'b0;
    n_cmp++; if (valid_o !== 1'b1 || inst !== 32'h00100093 || err !== 1'b0) begin n_fail++; $display("FAIL mid_after got v=%b %h e=%b want v=1 00100093 e=0", valid_o, inst, err); end
  endtask
  initial begin
    test_reset;
    test_itype;
    test_back_to_back;
    test_backpressure;
    test_errors;
    test_saturation;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
